// File: rtl/fp_ieee_to_flopoco_sp_pkg.sv
// Shared single-precision definitions: exception encoding, field widths and word layouts.
// The snan pipeline bit exists only when FP_SNAN_FLAG_EN is defined.
package fp_ieee_to_flopoco_sp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [FRAC_W-1:0] NAN_FRAC = 23'h400000;

    typedef struct packed {
        logic [1:0]        exc;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } sp_word_t;

    typedef struct packed {
        logic [1:0]        cls;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              ftz;
`ifdef FP_SNAN_FLAG_EN
        logic              snan;
`endif
    } dec_t;

    typedef struct packed {
        sp_word_t word;
        logic     ftz;
`ifdef FP_SNAN_FLAG_EN
        logic     snan;
`endif
    } out_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t              d;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e      = w[30:23];
        f      = w[22:0];
        d      = '0;
        d.sign = w[31];
        d.exp  = e;
        d.frac = f;
        if (e == '0) begin
            d.cls = EXC_ZERO;
            d.ftz = |f;
        end else if (&e) begin
            d.cls = (|f) ? EXC_NAN : EXC_INF;
        end else begin
            d.cls = EXC_NORMAL;
        end
`ifdef FP_SNAN_FLAG_EN
        d.snan = (&e) & (|f) & ~f[22];
`endif
        return d;
    endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// Generic valid/ready register slice; loads valid and data whenever en is high.
module fp_pipe_stage #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            // A drained stage with no new input clears its valid here.
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/fp_ieee_to_flopoco_sp.sv
// Two-stage IEEE-754 binary32 to 34-bit internal float converter with valid/ready flow control.
// Define FP_SNAN_FLAG_EN to add the out_snan port and its pipeline bit.
module fp_ieee_to_flopoco_sp (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [33:0] out_data,
    output logic        out_ftz
`ifdef FP_SNAN_FLAG_EN
    ,
    output logic        out_snan
`endif
);
    import fp_ieee_to_flopoco_sp_pkg::*;

    dec_t dec;
    dec_t s1_q;
    out_t asm_o;
    out_t s2_q;
    logic s1_valid;
    logic s2_valid;
    logic en1;
    logic en2;

    assign en2      = ~s2_valid | out_ready;
    assign en1      = ~s1_valid | en2;
    assign in_ready = en1;

    assign dec = decode(in_data);

    fp_pipe_stage #(
        .Width($bits(dec_t))
    ) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .in_valid (in_valid),
        .in_data  (dec),
        .out_valid(s1_valid),
        .out_data (s1_q)
    );

    always_comb begin
        asm_o           = '0;
        asm_o.word.exc  = s1_q.cls;
        asm_o.word.sign = s1_q.sign;
        asm_o.ftz       = s1_q.ftz;
        unique case (s1_q.cls)
            EXC_NORMAL: begin
                asm_o.word.exp  = s1_q.exp;
                asm_o.word.frac = s1_q.frac;
            end
            EXC_NAN: begin
                // Every NaN collapses to the canonical positive quiet NaN.
                asm_o.word.sign = 1'b0;
                asm_o.word.frac = NAN_FRAC;
            end
            default: ;
        endcase
`ifdef FP_SNAN_FLAG_EN
        asm_o.snan = s1_q.snan;
`endif
    end

    fp_pipe_stage #(
        .Width($bits(out_t))
    ) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en2),
        .in_valid (s1_valid),
        .in_data  (asm_o),
        .out_valid(s2_valid),
        .out_data (s2_q)
    );

    assign out_valid = s2_valid;
    assign out_data  = s2_q.word;
    assign out_ftz   = s2_q.ftz;
`ifdef FP_SNAN_FLAG_EN
    assign out_snan  = s2_q.snan;
`endif

endmodule

// File: tb/tb_fp_ieee_to_flopoco_sp.sv
// Self-checking bench: randomized traffic against a scoreboard fed by a behavioural model.
module tb_fp_ieee_to_flopoco_sp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [33:0] out_data;
    logic        out_ftz;
`ifdef FP_SNAN_FLAG_EN
    logic        out_snan;
`endif

    always #5 clk = ~clk;

    fp_ieee_to_flopoco_sp dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ftz  (out_ftz)
`ifdef FP_SNAN_FLAG_EN
        ,
        .out_snan (out_snan)
`endif
    );

    typedef struct {
        logic [33:0] data;
        logic        ftz;
        logic        snan;
        int          cyc;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_out = 0;
    bit          lat_chk = 0;
    logic        hs_in = 1'b0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_data = '0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] tx_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference conversion straight from the class rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        r;
        int          ex;
        int          fr;
        logic        s;
        logic [33:0] nan_word;
        ex       = int'(w[30:23]);
        fr       = int'(w[22:0]);
        s        = w[31];
        nan_word = 34'h300400000;
        r.ftz    = 1'b0;
        r.snan   = 1'b0;
        r.cyc    = 0;
        if (ex == 0) begin
            r.data = {2'b00, s, 31'd0};
            r.ftz  = (fr != 0);
        end else if (ex == 255) begin
            if (fr == 0) begin
                r.data = {2'b10, s, 31'd0};
            end else begin
                r.data = nan_word;
                r.snan = (fr < 'h400000);
            end
        end else begin
            r.data = {2'b01, w};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hs_in      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
            end
            hs_in = in_valid && in_ready;
            if (hs_in) begin
                e     = model(in_data);
                e.cyc = cyc;
                sb.push_back(e);
                n_acc++;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_ftz", 64'(out_ftz), 64'(e.ftz));
`ifdef FP_SNAN_FLAG_EN
                    chk("out_snan", 64'(out_snan), 64'(e.snan));
`endif
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        logic [7:0]  ex;
        logic [22:0] fr;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(7);
        fr  = r[22:0];
        ex  = 8'($urandom_range(254, 1));
        case (sel)
            0: begin ex = 8'd0;   fr = '0; end
            1: begin ex = 8'd0;   fr = r[22:0] | 23'd1; end
            2: begin ex = 8'd255; fr = '0; end
            3: begin ex = 8'd255; fr = r[22:0] | 23'd1; end
            4: begin ex = 8'd255; fr = {1'b0, r[21:0] | 22'd1}; end
            default: ;
        endcase
        return {r[31], ex, fr};
    endfunction

    task automatic drive(input int vpct, input int rpct, input int budget);
        int b;
        b = 0;
        while (tx_q.size() > 0 && b < budget) begin
            in_valid  = ($urandom_range(99) < vpct);
            in_data   = in_valid ? tx_q[0] : $urandom;
            out_ready = ($urandom_range(99) < rpct);
            tick();
            if (hs_in) void'(tx_q.pop_front());
            b++;
        end
        chk("send_done", 64'(tx_q.size()), 64'd0);
        tx_q.delete();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp[5];
        int          k;
        int          base;
        exp_t        m;

        // Pin the model to hand-computed words.
        m = model(32'h3F800000); chk("pin_one", 64'(m.data), 64'h13F800000);
        m = model(32'h80000000); chk("pin_negz", 64'(m.data), 64'h080000000);
        m = model(32'h00000001); chk("pin_sub", 64'({m.data, m.ftz}), 64'({34'h0, 1'b1}));
        m = model(32'hFF800000); chk("pin_ninf", 64'(m.data), 64'h280000000);
        m = model(32'hFFC00001); chk("pin_qnan", 64'({m.data, m.snan}), 64'({34'h300400000, 1'b0}));
        m = model(32'h7F800001); chk("pin_snan", 64'({m.data, m.snan}), 64'({34'h300400000, 1'b1}));

        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ftz", 64'(out_ftz), 64'd0);
`ifdef FP_SNAN_FLAG_EN
        chk("rst_out_snan", 64'(out_snan), 64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        tx_q = '{32'h3F800000, 32'h80000000, 32'h00000001, 32'hFF800000,
                 32'hFFC00001, 32'h7F800001};
        drive(100, 100, 50);
        drain(50);

        // Backpressure: stalled output fills both stages after two words.
        bp   = '{32'h40000000, 32'h00400000, 32'h7F800000, 32'hC1200000, 32'h7FA00000};
        base = n_out;
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bp[k];
            tick();
            if (hs_in) k++;
        end
        chk("bp_accepted", 64'(k), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && k < 5; i++) begin
            in_valid = 1'b1;
            in_data  = bp[k];
            tick();
            if (hs_in) k++;
        end
        drain(50);
        chk("bp_count", 64'(n_out - base), 64'd5);

        // Full rate with latency tracking.
        lat_chk = 1;
        base    = n_acc;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = rand_word();
            tick();
        end
        chk("full_rate_accepts", 64'(n_acc - base), 64'd100);
        drain(50);
        lat_chk = 0;

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) tx_q.push_back(rand_word());
        drive(70, 60, 5000);
        drain(100);

        // Asynchronous reset with two words in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        tick();
        in_data   = 32'h40490FDB;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("inflight_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rerst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("no_stale_out", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
